// File: rtl/seg7_time_scanner.sv
// Eight-digit multiplexed seven-segment driver for the countdown timer.
// Optional leading-zero blanking of h2: define SEG7_LEAD_ZERO_BLANK_EN.
module seg7_time_scanner #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] time_i,
  input  logic [2:0]  curr_digit,
  input  logic        edit,
  input  logic        done,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    p_q, p_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;

  // ms1 is never shown, so only nibbles h2..ms2 are kept
  logic [31:0]   snap_t_q, snap_t_d;
  logic [2:0]    snap_cd_q, snap_cd_d;
  logic          snap_ed_q, snap_ed_d;
  logic          snap_dn_q, snap_dn_d;

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          scan_wrap;
  logic          blink_wrap;
  logic          frame_end;
  logic [3:0]    nib;
  logic          ed_blank;
  logic          dn_blank;
  logic          lz_blank;
  logic          unused_ms1;

  assign unused_ms1 = ^time_i[3:0];

  assign scan_wrap  = (scan_q == SW'(SCAN_DIV - 1));
  assign blink_wrap = (blink_q == BW'(BLINK_DIV - 1));
  assign frame_end  = scan_wrap && (p_q == 3'd7);

  always_comb begin
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    p_d       = scan_wrap ? p_q + 3'd1 : p_q;
    blink_d   = blink_wrap ? '0 : blink_q + 1'b1;
    phase_d   = blink_wrap ? ~phase_q : phase_q;
    snap_t_d  = snap_t_q;
    snap_cd_d = snap_cd_q;
    snap_ed_d = snap_ed_q;
    snap_dn_d = snap_dn_q;
    // whole frame decodes from one coherent capture
    if (frame_end) begin
      snap_t_d  = time_i[35:4];
      snap_cd_d = curr_digit;
      snap_ed_d = edit;
      snap_dn_d = done;
    end
  end

  assign nib = snap_t_q[{p_q, 2'b00} +: 4];

  assign ed_blank = snap_ed_q && (snap_cd_q <= 3'd5) && phase_q &&
                    (p_q == 3'd7 - snap_cd_q);
  assign dn_blank = !snap_ed_q && snap_dn_q && phase_q;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  assign lz_blank = (p_q == 3'd7) && (snap_t_q[31:28] == 4'd0) &&
                    !(snap_ed_q && (snap_cd_q == 3'd0));
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_d = 7'b0111111;
    unique case (nib)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
    dp_d = !((p_q == 3'd6) || (p_q == 3'd4) || (p_q == 3'd2));
    an_d = ~(8'd1 << p_q);
    if (ed_blank || dn_blank || lz_blank) an_d = 8'hFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= '0;
      p_q       <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      snap_t_q  <= '0;
      snap_cd_q <= '0;
      snap_ed_q <= 1'b0;
      snap_dn_q <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      scan_q    <= scan_d;
      p_q       <= p_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      snap_t_q  <= snap_t_d;
      snap_cd_q <= snap_cd_d;
      snap_ed_q <= snap_ed_d;
      snap_dn_q <= snap_dn_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_time_scanner.sv
// Directed bench for seg7_time_scanner (SCAN_DIV=4, BLINK_DIV=16).
// Honours SEG7_LEAD_ZERO_BLANK_EN for the h2 expectations.
module tb_seg7_time_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] time_i;
  logic [2:0]  curr_digit;
  logic        edit;
  logic        done;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  localparam logic [7:0] H2Z_AN = 8'hFF;
`else
  localparam logic [7:0] H2Z_AN = 8'h7F;
`endif

  seg7_time_scanner #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .time_i     (time_i),
    .curr_digit (curr_digit),
    .edit       (edit),
    .done       (done),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input int target);
    while (k < target) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic out(input string tag, input logic [7:0] a,
                     input logic [6:0] s, input logic d);
    chk({tag, ".an"}, an_o, a);
    chk({tag, ".seg"}, {1'b0, seg_o}, {1'b0, s});
    chk({tag, ".dp"}, {7'd0, dp_o}, {7'd0, d});
  endtask

  initial begin
    rst        = 1'b1;
    time_i     = 36'h123456789;
    curr_digit = 3'd0;
    edit       = 1'b0;
    done       = 1'b0;
    #22;
    out("reset", 8'hFF, 7'h7F, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    go(1);   out("f1p0", 8'hFE, 7'h40, 1'b1);
    go(5);   out("f1p1", 8'hFD, 7'h40, 1'b1);
    go(9);   out("f1p2", 8'hFB, 7'h40, 1'b0);
    go(29);  out("f1p7", H2Z_AN, 7'h40, 1'b1);
    go(33);  out("f2p0", 8'hFE, 7'h00, 1'b1);
    go(37);  out("f2p1", 8'hFD, 7'h78, 1'b1);
    go(49);  out("f2p4", 8'hEF, 7'h19, 1'b0);
    go(57);  out("f2p6", 8'hBF, 7'h24, 1'b0);
    go(61);  out("f2p7", 8'h7F, 7'h79, 1'b1);

    edit = 1'b1;
    curr_digit = 3'd2;
    go(81);  out("ed2p4", 8'hEF, 7'h19, 1'b0);
    go(85);  out("ed2p5", 8'hFF, 7'h30, 1'b1);

    curr_digit = 3'd5;
    go(105); out("ed5p2", 8'hFB, 7'h02, 1'b0);
    go(117); out("ed5p5", 8'hDF, 7'h30, 1'b1);

    edit = 1'b0;
    done = 1'b1;
    time_i = 36'h0;
    go(129); out("dn_p0", 8'hFE, 7'h40, 1'b1);
    go(145); out("dn_p4", 8'hFF, 7'h40, 1'b0);
    go(157); out("dn_p7", 8'hFF, 7'h40, 1'b1);

    edit = 1'b1;
    curr_digit = 3'd7;
    go(177); out("ed7p4", 8'hEF, 7'h40, 1'b0);
    go(189); out("ed7p7", H2Z_AN, 7'h40, 1'b1);

    edit = 1'b0;
    done = 1'b0;
    curr_digit = 3'd0;
    time_i = 36'h000000C00;
    go(193); out("dashp0", 8'hFE, 7'h40, 1'b1);
    time_i = 36'h000000500;
    go(197); out("dashp1", 8'hFD, 7'h3F, 1'b1);
    go(229); out("newp1", 8'hFD, 7'h12, 1'b1);

    go(241); out("prerst", 8'hEF, 7'h40, 1'b0);
    rst = 1'b1;
    #1;
    out("asyncrst", 8'hFF, 7'h7F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    go(1);   out("r_p0", 8'hFE, 7'h40, 1'b1);
    go(5);   out("r_p1", 8'hFD, 7'h40, 1'b1);
    go(29);  out("r_p7", H2Z_AN, 7'h40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
